// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus optional iterative shift-add multiplier.
// Define EX_MUL_EN to build the MUL FSM; otherwise op 6 retires as a NOP.
module ex_stage #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        IR_in,
    input  logic [WIDTH-3:0]        PC_in,
    input  logic [REG_ADDR_LEN-1:0] Rd_no_in,
    input  logic [WIDTH-1:0]        Rs_data_in,
    input  logic [WIDTH-1:0]        Rt_data_in,
    output logic                    valid_out,
    output logic                    wr_en_out,
    output logic [WIDTH-1:0]        result_out,
    output logic [REG_ADDR_LEN-1:0] Rd_no_out,
    output logic [WIDTH-3:0]        PC_out
);

    localparam int unsigned PC_W = WIDTH - 2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    logic [5:0]              w_op;
    logic [WIDTH-1:0]        w_imm;
    logic [WIDTH-1:0]        w_opb;
    logic [WIDTH-1:0]        w_alu;
    logic                    w_is_nop;
    logic                    w_alu_wr;
    logic                    w_unused;

    logic                    r_valid,  w_valid_nxt;
    logic                    r_wr_en,  w_wr_en_nxt;
    logic [WIDTH-1:0]        r_result, w_result_nxt;
    logic [REG_ADDR_LEN-1:0] r_rd,     w_rd_nxt;
    logic [PC_W-1:0]         r_pc,     w_pc_nxt;

    assign w_op     = IR_in[WIDTH-1 -: 6];
    assign w_imm    = {{(WIDTH-16){IR_in[15]}}, IR_in[15:0]};
    assign w_opb    = w_op[5] ? w_imm : Rt_data_in;
    // op[4:3] and the middle instruction bits carry no meaning in this stage
    assign w_unused = ^{IR_in[WIDTH-7:16], w_op[4:3]};

    // Single-cycle ALU
    always_comb begin
        w_alu = '0;
        case (w_op[2:0])
            OP_ADD:  w_alu = Rs_data_in + w_opb;
            OP_SUB:  w_alu = Rs_data_in - w_opb;
            OP_AND:  w_alu = Rs_data_in & w_opb;
            OP_OR:   w_alu = Rs_data_in | w_opb;
            OP_XOR:  w_alu = Rs_data_in ^ w_opb;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(Rs_data_in) < $signed(w_opb))};
            default: w_alu = '0;
        endcase
    end

`ifdef EX_MUL_EN
    assign w_is_nop = (w_op[2:0] == OP_NOP);
`else
    assign w_is_nop = (w_op[2:0] == OP_NOP) || (w_op[2:0] == OP_MUL);
`endif
    assign w_alu_wr = !w_is_nop && (Rd_no_in != '0);

`ifdef EX_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t                  r_state,  w_state_nxt;
    logic [WIDTH-1:0]        r_mul_a,  w_mul_a_nxt;
    logic [WIDTH-1:0]        r_mul_b,  w_mul_b_nxt;
    logic [WIDTH-1:0]        r_acc,    w_acc_nxt;
    logic [WIDTH-1:0]        w_acc_step;
    logic [CNT_W-1:0]        r_cnt,    w_cnt_nxt;
    logic [REG_ADDR_LEN-1:0] r_mul_rd, w_mul_rd_nxt;
    logic [PC_W-1:0]         r_mul_pc, w_mul_pc_nxt;

    assign in_ready   = (r_state == S_IDLE);
    assign w_acc_step = r_acc + (r_mul_b[0] ? r_mul_a : '0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, multiplier datapath and output next values
    always_comb begin
        w_state_nxt  = r_state;
        w_mul_a_nxt  = r_mul_a;
        w_mul_b_nxt  = r_mul_b;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_mul_rd_nxt = r_mul_rd;
        w_mul_pc_nxt = r_mul_pc;
        w_valid_nxt  = 1'b0;
        w_wr_en_nxt  = 1'b0;
        w_result_nxt = r_result;
        w_rd_nxt     = r_rd;
        w_pc_nxt     = r_pc;

        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && (w_op[2:0] == OP_MUL)) begin
                        w_state_nxt  = S_MUL;
                        w_mul_a_nxt  = Rs_data_in;
                        w_mul_b_nxt  = w_opb;
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = CNT_W'(WIDTH);
                        w_mul_rd_nxt = Rd_no_in;
                        w_mul_pc_nxt = PC_in;
                    end else if (in_valid) begin
                        w_valid_nxt  = 1'b1;
                        w_wr_en_nxt  = w_alu_wr;
                        w_result_nxt = w_is_nop ? '0 : w_alu;
                        w_rd_nxt     = Rd_no_in;
                        w_pc_nxt     = PC_in;
                    end
                end
                S_MUL: begin
                    w_acc_nxt   = w_acc_step;
                    w_mul_a_nxt = r_mul_a << 1;
                    w_mul_b_nxt = r_mul_b >> 1;
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    // last iteration: retire including this edge's partial product
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt  = S_IDLE;
                        w_valid_nxt  = 1'b1;
                        w_wr_en_nxt  = (r_mul_rd != '0);
                        w_result_nxt = w_acc_step;
                        w_rd_nxt     = r_mul_rd;
                        w_pc_nxt     = r_mul_pc;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Multiplier operand registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mul_rd <= '0;
            r_mul_pc <= '0;
        end else begin
            r_mul_a  <= w_mul_a_nxt;
            r_mul_b  <= w_mul_b_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mul_rd <= w_mul_rd_nxt;
            r_mul_pc <= w_mul_pc_nxt;
        end
    end
`else
    assign in_ready = 1'b1;

    // Output next values: every accepted op retires one cycle later
    always_comb begin
        w_valid_nxt  = 1'b0;
        w_wr_en_nxt  = 1'b0;
        w_result_nxt = r_result;
        w_rd_nxt     = r_rd;
        w_pc_nxt     = r_pc;
        if (!flush && in_valid) begin
            w_valid_nxt  = 1'b1;
            w_wr_en_nxt  = w_alu_wr;
            w_result_nxt = w_is_nop ? '0 : w_alu;
            w_rd_nxt     = Rd_no_in;
            w_pc_nxt     = PC_in;
        end
    end
`endif

    // EX/MEM-facing output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_wr_en  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
            r_pc     <= '0;
        end else begin
            r_valid  <= w_valid_nxt;
            r_wr_en  <= w_wr_en_nxt;
            r_result <= w_result_nxt;
            r_rd     <= w_rd_nxt;
            r_pc     <= w_pc_nxt;
        end
    end

    assign valid_out  = r_valid;
    assign wr_en_out  = r_wr_en;
    assign result_out = r_result;
    assign Rd_no_out  = r_rd;
    assign PC_out     = r_pc;

endmodule
